rob_multi: RTL and testbench

ROB_MULTI -- requirements
Module: rob_multi

---
 rtl/rob_multi.sv | 140 ++++++++++++++
 tb/tb_rob_multi.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multi.sv
// Reorder buffer with multiple CDB capture ports. Tags 1..DEPTH-1 name the
// slots; tag 0 means "no tag" and never addresses a live entry.
package rob_multi_pkg;
  localparam int TAG_W  = 8;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [TAG_W-1:0]  ROB_number;
    logic [1:0]        itype;
    logic              ready;
    logic [DATA_W-1:0] value;
    logic              branch_result;
  } ROB_entry_t;

  typedef struct packed {
    logic [TAG_W-1:0]  dest_ROB_entry;
    logic [DATA_W-1:0] result;
    logic              branch_result;
  } CDB_packet_t;
endpackage

module rob_multi
  import rob_multi_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int NUM_CDB = 2,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  ROB_entry_t                new_entry,
  input  CDB_packet_t [NUM_CDB-1:0] CDB_in,
  input  logic                      rd_en,
  input  logic                      flush,
  output ROB_entry_t                head,
  output logic                      head_valid,
  output logic                      head_ready,
  output logic                      ROB_head_store,
  output logic                      full,
  output logic                      empty,
  output logic [IDX_W-1:0]          ROB_entry,
  output logic [IDX_W-1:0]          count
);

  localparam logic [IDX_W-1:0] LAST_TAG = IDX_W'(DEPTH - 1);

  ROB_entry_t       slots [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [IDX_W-1:0] wptr;
  logic [IDX_W-1:0] rptr;
  logic [IDX_W-1:0] cnt;
  logic             do_enq;
  logic             do_deq;
  ROB_entry_t       enq_entry;

  // Pointers skip slot 0 so that tag 0 stays reserved.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
    return (p == LAST_TAG) ? IDX_W'(1) : p + IDX_W'(1);
  endfunction

  assign full   = (cnt == LAST_TAG);
  assign empty  = (cnt == '0);
  assign do_enq = wr_en && !full && !flush;
  assign do_deq = rd_en && !empty && !flush;

  // Build the stored form of an incoming entry: own tag, and not ready
  // unless it is a store that arrives already complete.
  always_comb begin
    enq_entry            = new_entry;
    enq_entry.ROB_number = TAG_W'(wptr);
    enq_entry.ready      = (new_entry.itype == 2'b01) ? new_entry.ready : 1'b0;
  end

  // Control state: pointers, count and slot valid bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= IDX_W'(1);
      rptr <= IDX_W'(1);
      cnt  <= '0;
      vld  <= '0;
    end else if (flush) begin
      wptr <= IDX_W'(1);
      rptr <= IDX_W'(1);
      cnt  <= '0;
      vld  <= '0;
    end else begin
      // Enqueue and dequeue never hit the same slot: wptr == rptr only
      // when empty (no dequeue) or full (no enqueue).
      if (do_enq) begin
        vld[wptr] <= 1'b1;
        wptr      <= next_ptr(wptr);
      end
      if (do_deq) begin
        vld[rptr] <= 1'b0;
        rptr      <= next_ptr(rptr);
      end
      case ({do_enq, do_deq})
        2'b10:   cnt <= cnt + IDX_W'(1);
        2'b01:   cnt <= cnt - IDX_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Slot payload: enqueue write, else CDB capture into live slots. Later
  // ports are applied last so the highest-index port wins a tag collision.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_enq && (wptr == IDX_W'(i))) begin
        slots[i] <= enq_entry;
      end else if (vld[i]) begin
        for (int p = 0; p < NUM_CDB; p++) begin
          if ((CDB_in[p].dest_ROB_entry != '0) &&
              (CDB_in[p].dest_ROB_entry == slots[i].ROB_number)) begin
            case (slots[i].itype)
              2'b00: begin
                slots[i].branch_result <= CDB_in[p].branch_result;
                slots[i].ready         <= 1'b1;
              end
              2'b10, 2'b11: begin
                slots[i].value <= CDB_in[p].result;
                slots[i].ready <= 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign head           = slots[rptr];
  assign head_valid     = !empty;
  assign head_ready     = head_valid && head.ready;
  assign ROB_head_store = head_valid && (head.itype == 2'b01);
  assign ROB_entry      = full ? '0 : wptr;
  assign count          = cnt;

endmodule

// File: tb/tb_rob_multi.sv
// Bench for rob_multi: directed scenarios followed by random traffic, all
// compared each cycle against a queue-based model of the buffer.
module tb_rob_multi;
  import rob_multi_pkg::*;

  localparam int DEPTH   = 16;
  localparam int NUM_CDB = 2;
  localparam int IDX_W   = 4;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      wr_en;
  ROB_entry_t                new_entry;
  CDB_packet_t [NUM_CDB-1:0] CDB_in;
  logic                      rd_en;
  logic                      flush;
  ROB_entry_t                head;
  logic                      head_valid;
  logic                      head_ready;
  logic                      ROB_head_store;
  logic                      full;
  logic                      empty;
  logic [IDX_W-1:0]          ROB_entry;
  logic [IDX_W-1:0]          count;

  rob_multi #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .new_entry(new_entry),
    .CDB_in(CDB_in), .rd_en(rd_en), .flush(flush), .head(head),
    .head_valid(head_valid), .head_ready(head_ready),
    .ROB_head_store(ROB_head_store), .full(full), .empty(empty),
    .ROB_entry(ROB_entry), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic [1:0]  itype;
    logic        ready;
    logic [31:0] value;
    logic        br;
  } m_t;

  m_t q[$];
  int next_tag = 1;
  int errors   = 0;
  int checks   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all;
    bit hv;
    bit mfull;
    hv    = (q.size() > 0);
    mfull = (q.size() == DEPTH - 1);
    chk("count", 64'(count), 64'(q.size()));
    chk("full", 64'(full), 64'(mfull));
    chk("empty", 64'(empty), 64'(!hv));
    chk("rob_entry", 64'(ROB_entry), mfull ? 64'd0 : 64'(next_tag));
    chk("head_valid", 64'(head_valid), 64'(hv));
    chk("head_ready", 64'(head_ready), 64'(hv && q[0].ready));
    chk("head_store", 64'(ROB_head_store), 64'(hv && q[0].itype == 2'b01));
    if (hv) begin
      chk("head_tag", 64'(head.ROB_number), 64'(q[0].tag));
      chk("head_itype", 64'(head.itype), 64'(q[0].itype));
      chk("head_value", 64'(head.value), 64'(q[0].value));
      chk("head_br", 64'(head.branch_result), 64'(q[0].br));
    end
  endtask

  // Model of one clock edge, using the inputs as seen at that edge.
  task automatic model_step;
    bit was_full;
    m_t e;
    was_full = (q.size() == DEPTH - 1);
    if (reset || flush) begin
      q.delete();
      next_tag = 1;
      return;
    end
    for (int p = 0; p < NUM_CDB; p++) begin
      if (CDB_in[p].dest_ROB_entry != 0) begin
        foreach (q[i]) begin
          if (q[i].tag == int'(CDB_in[p].dest_ROB_entry)) begin
            if (q[i].itype == 2'b00) begin
              q[i].br = CDB_in[p].branch_result;
              q[i].ready = 1'b1;
            end else if (q[i].itype != 2'b01) begin
              q[i].value = CDB_in[p].result;
              q[i].ready = 1'b1;
            end
          end
        end
      end
    end
    if (rd_en && q.size() > 0) void'(q.pop_front());
    if (wr_en && !was_full) begin
      e.tag   = next_tag;
      e.itype = new_entry.itype;
      e.ready = (new_entry.itype == 2'b01) ? new_entry.ready : 1'b0;
      e.value = new_entry.value;
      e.br    = new_entry.branch_result;
      q.push_back(e);
      next_tag = (next_tag == DEPTH - 1) ? 1 : next_tag + 1;
    end
  endtask

  task automatic step;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle;
    wr_en  = 1'b0;
    rd_en  = 1'b0;
    flush  = 1'b0;
    CDB_in = '0;
  endtask

  task automatic set_entry(input logic [1:0] it, input logic rdy, input logic [31:0] val, input logic br);
    new_entry.ROB_number    = 8'($urandom);
    new_entry.itype         = it;
    new_entry.ready         = rdy;
    new_entry.value         = val;
    new_entry.branch_result = br;
  endtask

  task automatic cdb(input int p, input int dest, input logic [31:0] res, input logic br);
    CDB_in[p].dest_ROB_entry = 8'(dest);
    CDB_in[p].result         = res;
    CDB_in[p].branch_result  = br;
  endtask

  initial begin
    logic [1:0] its [7];
    its = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b11};
    reset = 1'b1;
    idle();
    set_entry(2'b10, 1'b0, 32'h0, 1'b0);
    #12;
    check_all();
    step();
    @(negedge clk);
    reset = 1'b0;

    // Fill to capacity, then one extra enqueue that must be dropped.
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1;
      set_entry(2'b10, 1'b1, 32'h100 + 32'(i), 1'b0);
      step();
    end
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_count", 64'(count), 64'd15);
    wr_en = 1'b0;

    // Wrap: dequeue three, enqueue three into tags 1..3.
    rd_en = 1'b1;
    repeat (3) step();
    rd_en = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_entry(2'b11, 1'b0, 32'h200 + 32'(i), 1'b0);
      step();
    end
    wr_en = 1'b0;
    chk("wrap_head_tag", 64'(head.ROB_number), 64'd4);

    // Dual CDB capture on tags 5 (itype 10) and 6 (itype 00); tag 7 sees
    // both ports at once.
    flush = 1'b1;
    step();
    flush = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      set_entry(its[i], 1'b0, 32'h0, 1'b0);
      step();
    end
    wr_en = 1'b0;
    cdb(0, 5, 32'hDEAD, 1'b0);
    cdb(1, 6, 32'h0, 1'b1);
    step();
    cdb(0, 7, 32'h1111, 1'b0);
    cdb(1, 7, 32'h2222, 1'b0);
    step();
    CDB_in = '0;
    rd_en  = 1'b1;
    repeat (4) step();
    rd_en = 1'b0;
    chk("cdb_p0_value", 64'(head.value), 64'hDEAD);
    chk("cdb_p0_ready", 64'(head_ready), 64'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("cdb_p1_br", 64'(head.branch_result), 64'd1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("cdb_same_tag", 64'(head.value), 64'h2222);

    // Boundaries at count 7: enq+deq, CDB on dequeued tag, tag 0, empty read.
    flush = 1'b1;
    step();
    flush = 1'b0;
    wr_en = 1'b1;
    repeat (7) begin
      set_entry(2'b10, 1'b0, $urandom, 1'b0);
      step();
    end
    rd_en = 1'b1;
    step();
    chk("enq_deq_count", 64'(count), 64'd7);
    wr_en = 1'b0;
    cdb(0, q[0].tag, 32'hBEEF, 1'b0);
    step();
    rd_en = 1'b0;
    cdb(0, 0, 32'h5555, 1'b1);
    cdb(1, 0, 32'h6666, 1'b1);
    step();
    CDB_in = '0;
    rd_en  = 1'b1;
    repeat (8) step();
    chk("rd_empty_count", 64'(count), 64'd0);
    rd_en = 1'b0;

    // Flush with every other request asserted.
    wr_en = 1'b1;
    repeat (10) begin
      set_entry(2'b10, 1'b0, $urandom, 1'b0);
      step();
    end
    rd_en = 1'b1;
    flush = 1'b1;
    step();
    chk("flush_empty", 64'(empty), 64'd1);
    chk("flush_rob_entry", 64'(ROB_entry), 64'd1);
    idle();
    cdb(0, 3, 32'h7777, 1'b1);
    cdb(1, 8, 32'h8888, 1'b1);
    step();
    CDB_in = '0;
    wr_en  = 1'b1;
    repeat (3) begin
      set_entry(2'b10, 1'b0, 32'h42, 1'b0);
      step();
    end
    wr_en = 1'b0;

    // Asynchronous reset between clock edges.
    wr_en = 1'b1;
    repeat (4) begin
      set_entry(2'b00, 1'b0, $urandom, 1'b0);
      step();
    end
    #2;
    reset = 1'b1;
    #1;
    q.delete();
    next_tag = 1;
    check_all();
    chk("async_empty", 64'(empty), 64'd1);
    idle();
    step();
    @(negedge clk);
    reset = 1'b0;

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      wr_en = ($urandom_range(0, 99) < 60);
      rd_en = ($urandom_range(0, 99) < 45);
      flush = ($urandom_range(0, 99) < 2);
      set_entry(2'($urandom), 1'($urandom), $urandom, 1'($urandom));
      for (int p = 0; p < NUM_CDB; p++) begin
        if (q.size() > 0 && $urandom_range(0, 1) == 1)
          cdb(p, q[$urandom_range(0, q.size() - 1)].tag, $urandom, 1'($urandom));
        else
          cdb(p, $urandom_range(0, DEPTH - 1), $urandom, 1'($urandom));
      end
      step();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
